// File: rtl/ps2_key_sequencer_pkg.sv
// Shared types and byte constants for the PS/2 key sequencer.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } state_t;

    localparam logic [7:0] PS2_EXT  = 8'hE0;
    localparam logic [7:0] PS2_BRK  = 8'hF0;
    localparam logic [7:0] PS2_ERR0 = 8'h00;
    localparam logic [7:0] PS2_ERR1 = 8'hFF;

    // The break flag is named rel because release is a reserved word.
    typedef struct packed {
        logic       ext;
        logic       rel;
        logic [7:0] code;
    } key_event_t;

endpackage

// File: rtl/ps2_key_sequencer_if.sv
// Scancode input and key-event output bundle for ps2_key_sequencer.
interface ps2_key_sequencer_if;

    logic [7:0] scancode;
    logic       code_strobe;
    logic [7:0] key_code;
    logic       key_ext;
    logic       key_release;
    logic       key_valid;
    logic       key_ready;
    logic       overflow;

    // Driver side: supplies bytes, consumes events.
    modport master (
        output scancode, code_strobe, key_ready,
        input  key_code, key_ext, key_release, key_valid, overflow
    );

    // Sequencer side.
    modport slave (
        input  scancode, code_strobe, key_ready,
        output key_code, key_ext, key_release, key_valid, overflow
    );

endinterface

// File: rtl/ps2_key_sequencer_fifo.sv
// Key event FIFO: power-of-two depth, head read from storage, sticky overflow.
module key_event_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  key_event_t push_data,
    input  logic       pop,
    output key_event_t head,
    output logic       empty,
    output logic       overflow
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;

    key_event_t     mem_q [DEPTH];
    key_event_t     mem_d [DEPTH];
    logic [AW-1:0]  wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           ovf_q, ovf_d;
    logic           full, do_push, do_pop;

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign head     = mem_q[rd_q];
    assign overflow = ovf_q;

    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        // A pop on empty is ignored; a pop on full frees the slot for a same-cycle push.
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        if (push && !do_push) begin
            ovf_d = 1'b1;
        end
        if (do_push) begin
            mem_d[wr_q] = push_data;
            wr_d        = wr_q + 1'b1;
        end
        if (do_pop) begin
            rd_d = rd_q + 1'b1;
        end
        if (do_push && !do_pop) begin
            cnt_d = cnt_q + 1'b1;
        end else if (do_pop && !do_push) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode-to-key-event sequencer: E0/F0 prefix FSM, prefix timeout, event FIFO.
// Define KEY_REPEAT_FILTER_EN to drop typematic repeats of the currently held key.
module ps2_key_sequencer
    import ps2_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
    input logic                clk,
    input logic                reset,
    ps2_key_sequencer_if.slave bus
);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t        state_q, state_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          emit, push;
    key_event_t    ev, head;
    logic          fifo_empty;
    logic          is_ext, is_brk, is_err;

    assign is_ext = (bus.scancode == PS2_EXT);
    assign is_brk = (bus.scancode == PS2_BRK);
    assign is_err = (bus.scancode == PS2_ERR0) || (bus.scancode == PS2_ERR1);

    always_comb begin
        state_d = state_q;
        tmo_d   = '0;
        emit    = 1'b0;
        ev      = '{ext: 1'b0, rel: 1'b0, code: bus.scancode};
        if (bus.code_strobe) begin
            if (is_err) begin
                state_d = IDLE;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (is_ext)      state_d = EXT;
                        else if (is_brk) state_d = BRK;
                        else             emit    = 1'b1;
                    end
                    EXT: begin
                        if (is_brk) begin
                            state_d = EXT_BRK;
                        end else if (!is_ext) begin
                            emit    = 1'b1;
                            ev.ext  = 1'b1;
                            state_d = IDLE;
                        end
                    end
                    BRK: begin
                        state_d = IDLE;
                        emit    = !is_ext && !is_brk;
                        ev.rel  = 1'b1;
                    end
                    EXT_BRK: begin
                        state_d = IDLE;
                        emit    = !is_ext && !is_brk;
                        ev.ext  = 1'b1;
                        ev.rel  = 1'b1;
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (state_q != IDLE) begin
            if (tmo_q == TMO_LAST) state_d = IDLE;
            else                   tmo_d   = tmo_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            tmo_q   <= tmo_d;
        end
    end

`ifdef KEY_REPEAT_FILTER_EN
    logic [8:0] held_q, held_d;
    logic       held_valid_q, held_valid_d;
    logic       held_match;

    assign held_match = held_valid_q && (held_q == {ev.ext, ev.code});

    always_comb begin
        held_d       = held_q;
        held_valid_d = held_valid_q;
        push         = emit;
        if (emit) begin
            if (!ev.rel) begin
                push         = !held_match;
                held_d       = {ev.ext, ev.code};
                held_valid_d = 1'b1;
            end else if (held_match) begin
                held_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            held_q       <= '0;
            held_valid_q <= 1'b0;
        end else begin
            held_q       <= held_d;
            held_valid_q <= held_valid_d;
        end
    end
`else
    assign push = emit;
`endif

    key_event_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (reset),
        .push     (push),
        .push_data(ev),
        .pop      (bus.key_ready),
        .head     (head),
        .empty    (fifo_empty),
        .overflow (bus.overflow)
    );

    assign bus.key_valid   = !fifo_empty;
    assign bus.key_code    = head.code;
    assign bus.key_ext     = head.ext;
    assign bus.key_release = head.rel;

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Directed self-checking bench for ps2_key_sequencer (DEPTH=4, TIMEOUT_CYCLES=16).
module tb_ps2_key_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;
    int   failed = 0;

    always #5 clk = ~clk;

    ps2_key_sequencer_if ifc ();

    ps2_key_sequencer #(
        .DEPTH         (4),
        .TIMEOUT_CYCLES(16)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (ifc.slave)
    );

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b);
        ifc.scancode    = b;
        ifc.code_strobe = 1'b1;
        tick(1);
        ifc.code_strobe = 1'b0;
        ifc.scancode    = 8'h00;
    endtask

    task automatic pop();
        ifc.key_ready = 1'b1;
        tick(1);
        ifc.key_ready = 1'b0;
    endtask

    task automatic chk_empty(input string tag);
        chk(tag, {7'b0, ifc.key_valid}, 8'd0);
    endtask

    task automatic expect_ev(input string tag, input logic e, input logic r, input logic [7:0] c);
        chk({tag, ".valid"}, {7'b0, ifc.key_valid}, 8'd1);
        chk({tag, ".code"}, ifc.key_code, c);
        chk({tag, ".ext"}, {7'b0, ifc.key_ext}, {7'b0, e});
        chk({tag, ".rel"}, {7'b0, ifc.key_release}, {7'b0, r});
        pop();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #3;
        rst = 1'b0;
        tick(1);
    endtask

    initial begin
        ifc.scancode    = 8'h00;
        ifc.code_strobe = 1'b0;
        ifc.key_ready   = 1'b0;
        #2;
        chk("rst.valid", {7'b0, ifc.key_valid}, 8'd0);
        chk("rst.code", ifc.key_code, 8'h00);
        chk("rst.ext", {7'b0, ifc.key_ext}, 8'd0);
        chk("rst.rel", {7'b0, ifc.key_release}, 8'd0);
        chk("rst.ovf", {7'b0, ifc.overflow}, 8'd0);
        #5;
        rst = 1'b0;
        tick(1);

        // Plain make with consumer ready: valid for exactly one cycle.
        ifc.key_ready = 1'b1;
        send(8'h1C);
        chk("make.valid", {7'b0, ifc.key_valid}, 8'd1);
        chk("make.code", ifc.key_code, 8'h1C);
        chk("make.ext", {7'b0, ifc.key_ext}, 8'd0);
        chk("make.rel", {7'b0, ifc.key_release}, 8'd0);
        tick(1);
        chk("make.gone", {7'b0, ifc.key_valid}, 8'd0);
        ifc.key_ready = 1'b0;

        // Prefix handling.
        do_reset();
        send(8'hE0);
        chk_empty("e0.noev");
        send(8'hF0);
        chk_empty("e0f0.noev");
        send(8'h75);
        expect_ev("extbrk", 1'b1, 1'b1, 8'h75);
        chk_empty("extbrk.single");
        send(8'hE0);
        send(8'hFF);
        send(8'h6B);
        expect_ev("errbyte", 1'b0, 1'b0, 8'h6B);
        send(8'hF0);
        send(8'hE0);
        chk_empty("proterr.noev");
        send(8'h74);
        expect_ev("proterr", 1'b0, 1'b0, 8'h74);
        send(8'hE0);
        send(8'hE0);
        send(8'h75);
        expect_ev("dupext", 1'b1, 1'b0, 8'h75);

        // Full with simultaneous push and pop: no drop, no overflow.
        do_reset();
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        ifc.key_ready = 1'b1;
        send(8'h2B);
        ifc.key_ready = 1'b0;
        chk("fullpp.ovf", {7'b0, ifc.overflow}, 8'd0);
        expect_ev("fullpp0", 1'b0, 1'b0, 8'h32);
        expect_ev("fullpp1", 1'b0, 1'b0, 8'h21);
        expect_ev("fullpp2", 1'b0, 1'b0, 8'h23);
        expect_ev("fullpp3", 1'b0, 1'b0, 8'h2B);
        chk_empty("fullpp.empty");

        // Overflow: fifth event dropped.
        do_reset();
        send(8'h1C);
        send(8'h32);
        send(8'h21);
        send(8'h23);
        chk("ovf.before", {7'b0, ifc.overflow}, 8'd0);
        send(8'h2B);
        chk("ovf.set", {7'b0, ifc.overflow}, 8'd1);
        expect_ev("ovf0", 1'b0, 1'b0, 8'h1C);
        expect_ev("ovf1", 1'b0, 1'b0, 8'h32);
        expect_ev("ovf2", 1'b0, 1'b0, 8'h21);
        expect_ev("ovf3", 1'b0, 1'b0, 8'h23);
        chk_empty("ovf.empty");
        chk("ovf.sticky", {7'b0, ifc.overflow}, 8'd1);

        // Asynchronous reset mid-sequence clears queue and overflow.
        send(8'h1C);
        send(8'h32);
        send(8'hE0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.valid", {7'b0, ifc.key_valid}, 8'd0);
        chk("arst.ovf", {7'b0, ifc.overflow}, 8'd0);
        #2;
        rst = 1'b0;
        tick(1);
        send(8'h75);
        expect_ev("arst.next", 1'b0, 1'b0, 8'h75);

        // Timeout: byte before timeout completes break, after timeout is a make.
        do_reset();
        send(8'hF0);
        tick(5);
        send(8'h1C);
        expect_ev("tmo.early", 1'b0, 1'b1, 8'h1C);
        send(8'hF0);
        tick(20);
        chk_empty("tmo.noev");
        send(8'h1C);
        expect_ev("tmo.late", 1'b0, 1'b0, 8'h1C);

        // Typematic repeat sequence 1C,1C,1C,F0,1C,1C.
        do_reset();
        send(8'h1C);
        expect_ev("rep0", 1'b0, 1'b0, 8'h1C);
        send(8'h1C);
`ifdef KEY_REPEAT_FILTER_EN
        chk_empty("rep1");
`else
        expect_ev("rep1", 1'b0, 1'b0, 8'h1C);
`endif
        send(8'h1C);
`ifdef KEY_REPEAT_FILTER_EN
        chk_empty("rep2");
`else
        expect_ev("rep2", 1'b0, 1'b0, 8'h1C);
`endif
        send(8'hF0);
        send(8'h1C);
        expect_ev("rep.brk", 1'b0, 1'b1, 8'h1C);
        send(8'h1C);
        expect_ev("rep.remake", 1'b0, 1'b0, 8'h1C);
        chk_empty("rep.end");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
